stepper_move_controller: RTL and testbench
==========================================

# stepper_move_controller

Sequences the stepper driver's `step`/`dir` lines from position commands. It accepts an absolute target over a valid/ready handshake, then emits a timed step pulse train toward that target. It tracks the current position and reports completion. It sits between the game control unit or serial command path and the motor pins, and feeds `db_current_pos` for the 7-segment debug display.

## Interface
Parameters:
- `POS_WIDTH`, 16: width of position and target, unsigned.
- `DIR_SETUP_CYCLES`, 50: cycles `dir` is held stable before the first pulse of a move. Must be ≥1.
- `STEP_HIGH_CYCLES`, 250: step pulse high time, in cycles. Must be ≥1.
- `STEP_PERIOD_CYCLES`, 50000: full step period, in cycles. Must be > `STEP_HIGH_CYCLES`.
- `POS_MIN`, 0 and `POS_MAX`, 16'hFFFF: soft limits. Used only with `STEPPER_LIMIT_EN`.

Ports:
- `clock` in 1: system clock. All logic on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `cmd_valid` in 1: a target is offered.
- `cmd_target` in POS_WIDTH: absolute target position.
- `cmd_ready` out 1: command can be accepted. High exactly when in IDLE.
- `abort` in 1: request early stop of the move in progress.
- `zero` in 1: set `current_pos` to 0. Honoured in IDLE only.
- `step` out 1: step pulse to the driver.
- `dir` out 1: 1 = increasing position, 0 = decreasing.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at the end of every accepted command.
- `aborted` out 1: valid with `done`. 1 = the move was cut short by `abort`.
- `limit_hit` out 1: valid with `done`. 1 = the target was clamped.
- `current_pos` out POS_WIDTH: registered position count.
- `db_estado` out 3: state encoding for debug. IDLE=0, DIR_SETUP=1, STEP_HIGH=2, STEP_LOW=3, DONE=4.

## Operation
- FSM states: IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW, DONE.
- IDLE:
  - `cmd_valid` is sampled and the target is latched into `tgt`.
  - If `tgt == current_pos`, go to DONE.
  - Otherwise set `dir` to `(tgt > current_pos)` and go to DIR_SETUP.
  - If `zero` and `cmd_valid` are both high in the same cycle, `zero` wins and the command is not accepted (`cmd_ready` is forced low that cycle).
- DIR_SETUP: lasts `DIR_SETUP_CYCLES` cycles, with `step`=0. Then go to STEP_HIGH.
- STEP_HIGH:
  - Lasts `STEP_HIGH_CYCLES` cycles, with `step`=1.
  - On the edge leaving this state, `current_pos` changes by ±1 according to `dir`.
- STEP_LOW:
  - Lasts `STEP_PERIOD_CYCLES − STEP_HIGH_CYCLES` cycles, with `step`=0.
  - Then go to DONE if `current_pos == tgt`, otherwise go to STEP_HIGH.
- DONE: one cycle. `done`=1, `aborted` and `limit_hit` valid. Then go to IDLE.
- `dir` changes only on command acceptance and is stable through the entire move. DIR_SETUP is always applied, even if `dir` did not change.
- Abort:
  - Sampled every cycle while busy; the request is held in a sticky flag that is cleared at DONE.
  - In DIR_SETUP or STEP_LOW: go to DONE on the next edge.
  - In STEP_HIGH: the pulse completes its full width and the position updates, then go to DONE.
  - Runt pulses are never generated.
- Arithmetic is unsigned. Motion is always toward `tgt`, so `current_pos` never wraps.
- A single cycle-count register of width `clog2(STEP_PERIOD_CYCLES)` is reloaded on every state entry.

## Timing
- Reset values: `step`=0, `dir`=0, `busy`=0, `done`=0, `aborted`=0, `limit_hit`=0, `current_pos`=0, `db_estado`=0. `cmd_ready`=1 (IDLE).
- Cycle references, for a command accepted at edge k with D=`DIR_SETUP_CYCLES`, H=`STEP_HIGH_CYCLES`, P=`STEP_PERIOD_CYCLES`:
  - `busy` rises in cycle k+1.
  - The first `step` high covers cycles k+D+1 to k+D+H.
  - Step n rises at cycle k+D+(n−1)·P+1.
- `current_pos` shows the updated value from cycle k+D+H+1 onward, and every P cycles after that.
- For an N-step move, `done` is high in cycle k+D+N·P+1. `cmd_ready` returns in the following cycle.
- For a zero-step command, `done` is high in cycle k+1.
- `zero` takes effect on the edge where it is sampled in IDLE.
- Reset asserted mid-move: `step` drops immediately and the position is lost (returns to 0).

## Configuration
- `STEPPER_LIMIT_EN` defined:
  - On acceptance, `tgt` = clamp(`cmd_target`, `POS_MIN`, `POS_MAX`).
  - `limit_hit`=1 at DONE when clamping changed the value.
- Not defined:
  - `tgt` = `cmd_target` unmodified.
  - `limit_hit` is tied to 0.
  - `POS_MIN`/`POS_MAX` are ignored.

## Test plan
Bench overrides: D=2, H=3, P=8.
- Reset, then command target 3 at edge k → `dir`=1, `step` high during k+3..k+5, k+11..k+13, k+19..k+21. `current_pos` reads 1, 2, 3. `done` is high at k+27 with `aborted`=0.
- From pos 3, command target 0 → `dir`=0 throughout, 3 pulses, `current_pos` ends at 0.
- From pos 0, command target 0 → `done` at k+1, `step` never asserted.
- Command target 10, assert `abort` in the middle of the 2nd pulse's high time → that pulse completes at full 3-cycle width, `current_pos`=2, then `done`=1 with `aborted`=1.
- In IDLE, `zero` and `cmd_valid` together → `current_pos`=0, command not accepted, `busy` stays 0.
- With `STEPPER_LIMIT_EN` and `POS_MAX`=5, command target 9 → 5 pulses, `current_pos`=5, `limit_hit`=1 at `done`.

Source files
------------

// File: rtl/stepper_move_controller_if.sv
// stepper_move_controller_if: command handshake, motor pins and status of the stepper move controller
interface stepper_move_controller_if #(parameter int POS_WIDTH = 16);
  logic                 cmd_valid;
  logic [POS_WIDTH-1:0] cmd_target;
  logic                 cmd_ready;
  logic                 abort;
  logic                 zero;
  logic                 step;
  logic                 dir;
  logic                 busy;
  logic                 done;
  logic                 aborted;
  logic                 limit_hit;
  logic [POS_WIDTH-1:0] current_pos;
  logic [2:0]           db_estado;
  modport master (
    output cmd_valid, cmd_target, abort, zero,
    input  cmd_ready, step, dir, busy, done, aborted, limit_hit, current_pos, db_estado
  );
  modport slave (
    input  cmd_valid, cmd_target, abort, zero,
    output cmd_ready, step, dir, busy, done, aborted, limit_hit, current_pos, db_estado
  );
endinterface

// File: rtl/stepper_move_controller.sv
// stepper_move_controller: timed step/dir pulse train toward an absolute target; STEPPER_LIMIT_EN enables soft-limit clamping
module stepper_move_controller #(
  parameter int                   POS_WIDTH          = 16,
  parameter int                   DIR_SETUP_CYCLES   = 50,
  parameter int                   STEP_HIGH_CYCLES   = 250,
  parameter int                   STEP_PERIOD_CYCLES = 50000,
  parameter logic [POS_WIDTH-1:0] POS_MIN            = '0,
  parameter logic [POS_WIDTH-1:0] POS_MAX            = {POS_WIDTH{1'b1}}
) (
  input logic                     clock,
  input logic                     reset,
  stepper_move_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, DIR_SETUP = 3'd1, STEP_HIGH = 3'd2, STEP_LOW = 3'd3, DONE = 3'd4} state_t;
  localparam int CW = $clog2(STEP_PERIOD_CYCLES);
  localparam logic [CW-1:0] SETUP_LD = CW'(DIR_SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LD  = CW'(STEP_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LD   = CW'(STEP_PERIOD_CYCLES - STEP_HIGH_CYCLES - 1);
  state_t st, nxt;
  logic [CW-1:0] cnt, cnt_ld;
  logic [POS_WIDTH-1:0] pos, tgt, tgt_n;
  logic dir_q, step_q, abort_q, limit_q, clip, accept, abrt, cnt_end;
`ifdef STEPPER_LIMIT_EN
  assign tgt_n = bus.cmd_target < POS_MIN ? POS_MIN : (bus.cmd_target > POS_MAX ? POS_MAX : bus.cmd_target);
  assign clip  = tgt_n != bus.cmd_target;
`else
  logic unused_lim;
  assign tgt_n      = bus.cmd_target;
  assign clip       = 1'b0;
  assign unused_lim = ^{POS_MIN, POS_MAX};
`endif
  // zero has priority over a command offered in the same cycle
  assign bus.cmd_ready = (st == IDLE) & ~bus.zero;
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign abrt          = abort_q | bus.abort;
  assign cnt_end       = cnt == '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:      nxt = accept ? (tgt_n == pos ? DONE : DIR_SETUP) : IDLE;
      DIR_SETUP: nxt = abrt ? DONE : (cnt_end ? STEP_HIGH : DIR_SETUP);
      STEP_HIGH: nxt = cnt_end ? (abrt ? DONE : STEP_LOW) : STEP_HIGH;
      STEP_LOW:  nxt = abrt ? DONE : (cnt_end ? (pos == tgt ? DONE : STEP_HIGH) : STEP_LOW);
      default:   nxt = IDLE;
    endcase
    cnt_ld = nxt == DIR_SETUP ? SETUP_LD : nxt == STEP_HIGH ? HIGH_LD : nxt == STEP_LOW ? LOW_LD : '0;
  end
  // step is registered so the pin never glitches across state-code transitions
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt     <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      abort_q <= 1'b0;
      limit_q <= 1'b0;
      tgt     <= '0;
      pos     <= '0;
    end else begin
      cnt     <= nxt != st ? cnt_ld : (cnt_end ? cnt : cnt - CW'(1));
      step_q  <= nxt == STEP_HIGH;
      abort_q <= st == DONE ? 1'b0 : (st != IDLE && bus.abort) ? 1'b1 : abort_q;
      if (accept) begin
        tgt     <= tgt_n;
        limit_q <= clip;
        if (tgt_n != pos) dir_q <= tgt_n > pos;
      end
      if (st == IDLE && bus.zero) pos <= '0;
      else if (st == STEP_HIGH && cnt_end) pos <= dir_q ? pos + POS_WIDTH'(1) : pos - POS_WIDTH'(1);
    end
  assign bus.step        = step_q;
  assign bus.dir         = dir_q;
  assign bus.busy        = st != IDLE;
  assign bus.done        = st == DONE;
  assign bus.aborted     = (st == DONE) & abort_q;
  assign bus.limit_hit   = (st == DONE) & limit_q;
  assign bus.current_pos = pos;
  assign bus.db_estado   = st;
endmodule

// File: tb/tb_stepper_move_controller.sv
// tb_stepper_move_controller: directed cycle-accurate checks of the stepper move controller with D=2, H=3, P=8
module tb_stepper_move_controller;
  localparam int D = 2, H = 3, P = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0, n_err = 0, exp_pos = 0;
  stepper_move_controller_if #(.POS_WIDTH(16)) bus ();
  stepper_move_controller #(
    .POS_WIDTH(16), .DIR_SETUP_CYCLES(D), .STEP_HIGH_CYCLES(H), .STEP_PERIOD_CYCLES(P),
    .POS_MIN(16'd0), .POS_MAX(16'd5)
  ) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run_move(input int target, input int nsteps, input int done_cyc, input int abort_cyc,
                          input bit exp_dir, input bit exp_ab, input bit exp_lim);
    int start, s;
    start = exp_pos;
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = target[15:0];
    @(posedge clock);
    for (int i = 1; i <= done_cyc; i++) begin
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      s = (i > D + H) ? (i - D - H - 1) / P + 1 : 0;
      if (s > nsteps) s = nsteps;
      chk("step", bus.step, (i > D && i < done_cyc && (i - D - 1) % P < H));
      chk("pos", bus.current_pos, exp_dir ? start + s : start - s);
      chk("done", bus.done, i == done_cyc);
      chk("busy", bus.busy, 1);
      chk("estado", bus.db_estado, i == done_cyc ? 4 : i <= D ? 1 : ((i - D - 1) % P < H) ? 2 : 3);
      if (nsteps > 0) chk("dir", bus.dir, exp_dir);
      if (i == done_cyc) begin
        chk("aborted", bus.aborted, exp_ab);
        chk("limit_hit", bus.limit_hit, exp_lim);
      end
      bus.abort = (i == abort_cyc);
    end
    exp_pos = exp_dir ? start + nsteps : start - nsteps;
    @(negedge clock);
    chk("ready_after", bus.cmd_ready, 1);
    chk("busy_after", bus.busy, 0);
    chk("pos_after", bus.current_pos, exp_pos);
  endtask
  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = '0;
    bus.abort      = 1'b0;
    bus.zero       = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_step", bus.step, 0);
    chk("rst_dir", bus.dir, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_aborted", bus.aborted, 0);
    chk("rst_limit", bus.limit_hit, 0);
    chk("rst_pos", bus.current_pos, 0);
    chk("rst_estado", bus.db_estado, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_ready", bus.cmd_ready, 1);
    run_move(3, 3, 27, 0, 1'b1, 1'b0, 1'b0);
    run_move(0, 3, 27, 0, 1'b0, 1'b0, 1'b0);
    run_move(0, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    run_move(10, 2, 14, 12, 1'b1, 1'b1, 1'b0);
    bus.zero       = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 16'd7;
    #1 chk("zero_ready", bus.cmd_ready, 0);
    @(negedge clock);
    chk("zero_pos", bus.current_pos, 0);
    chk("zero_busy", bus.busy, 0);
    bus.zero      = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_pos       = 0;
    @(negedge clock);
    chk("zero_busy2", bus.busy, 0);
    chk("zero_estado", bus.db_estado, 0);
`ifdef STEPPER_LIMIT_EN
    run_move(9, 5, D + 5 * P + 1, 0, 1'b1, 1'b0, 1'b1);
`else
    run_move(9, 9, D + 9 * P + 1, 0, 1'b1, 1'b0, 1'b0);
`endif
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 16'd0;
    @(posedge clock);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_step", bus.step, 1);
    chk("mid_pos", bus.current_pos, exp_pos);
    reset = 1'b1;
    #1;
    chk("arst_step", bus.step, 0);
    chk("arst_pos", bus.current_pos, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.cmd_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_estado", bus.db_estado, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
